// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with capture bypass, EX forwarding, load-use detection and ALU operand select.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [RA_W-1:0]   id_rt_addr,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_alusrc1,
  input  logic              id_alusrc2,
  input  logic [5:0]        id_alufun,
  input  logic              id_sign,
  input  logic [RA_W-1:0]   id_wr_addr,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              exmem_regwrite,
  input  logic [RA_W-1:0]   exmem_wr_addr,
  input  logic [DATA_W-1:0] exmem_res,
  input  logic              memwb_regwrite,
  input  logic [RA_W-1:0]   memwb_wr_addr,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              hold,
  input  logic              flush,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [5:0]        ex_alufun,
  output logic              ex_sign,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [DATA_W-1:0] ex_pc,
  output logic [RA_W-1:0]   ex_wr_addr,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              load_use_stall
);
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              alusrc1;
    logic              alusrc2;
    logic              sign;
    logic [RA_W-1:0]   rs_addr;
    logic [RA_W-1:0]   rt_addr;
    logic [RA_W-1:0]   wr_addr;
    logic [4:0]        shamt;
    logic [5:0]        alufun;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } ex_t;
  ex_t q, d;
  logic wb_rs, wb_rt, em_rs, em_rt, mw_rs, mw_rt;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  // The register file lacks write-through, so a same-cycle writeback is bypassed at capture.
  always_comb begin
    wb_rs = memwb_regwrite && memwb_wr_addr != '0 && memwb_wr_addr == id_rs_addr;
    wb_rt = memwb_regwrite && memwb_wr_addr != '0 && memwb_wr_addr == id_rt_addr;
    d = '0;
    d.valid = id_valid;
    d.regwrite = id_regwrite & id_valid;
    d.memread = id_memread & id_valid;
    d.memwrite = id_memwrite & id_valid;
    d.alusrc1 = id_alusrc1;
    d.alusrc2 = id_alusrc2;
    d.sign = id_sign;
    d.rs_addr = id_rs_addr;
    d.rt_addr = id_rt_addr;
    d.wr_addr = id_wr_addr;
    d.shamt = id_shamt;
    d.alufun = id_alufun;
    d.pc = id_pc;
    d.rs_data = wb_rs ? memwb_data : id_rs_data;
    d.rt_data = wb_rt ? memwb_data : id_rt_data;
    d.imm = id_imm;
  end
  always_comb begin
    load_use_stall = !flush && q.valid && q.memread && q.wr_addr != '0 && id_valid &&
                     ((id_use_rs && id_rs_addr == q.wr_addr) || (id_use_rt && id_rt_addr == q.wr_addr));
    em_rs = exmem_regwrite && exmem_wr_addr != '0 && exmem_wr_addr == q.rs_addr;
    em_rt = exmem_regwrite && exmem_wr_addr != '0 && exmem_wr_addr == q.rt_addr;
    mw_rs = memwb_regwrite && memwb_wr_addr != '0 && memwb_wr_addr == q.rs_addr;
    mw_rt = memwb_regwrite && memwb_wr_addr != '0 && memwb_wr_addr == q.rt_addr;
    fwd_rs = em_rs ? exmem_res : mw_rs ? memwb_data : q.rs_data;
    fwd_rt = em_rt ? exmem_res : mw_rt ? memwb_data : q.rt_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (!hold) q <= (flush || load_use_stall) ? '0 : d;
  end
  assign ex_a          = q.alusrc1 ? {{(DATA_W-5){1'b0}}, q.shamt} : fwd_rs;
  assign ex_b          = q.alusrc2 ? q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_alufun     = q.alufun;
  assign ex_sign       = q.sign;
  assign ex_pc         = q.pc;
  assign ex_wr_addr    = q.wr_addr;
  assign ex_valid      = q.valid;
  assign ex_regwrite   = q.regwrite;
  assign ex_memread    = q.memread;
  assign ex_memwrite   = q.memwrite;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage covering capture, bypass, forwarding, stalls, hold/flush and reset.
module tb_id_ex_stage;
  logic clk = 1'b0, reset = 1'b0;
  logic id_valid, id_use_rs, id_use_rt, id_alusrc1, id_alusrc2, id_sign;
  logic id_regwrite, id_memread, id_memwrite;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_rs_addr, id_rt_addr, id_shamt, id_wr_addr;
  logic [5:0] id_alufun;
  logic exmem_regwrite, memwb_regwrite, hold, flush;
  logic [4:0] exmem_wr_addr, memwb_wr_addr;
  logic [31:0] exmem_res, memwb_data;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [5:0] ex_alufun;
  logic [4:0] ex_wr_addr;
  logic ex_sign, ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_stall;
  logic [143:0] obs, e;
  logic [143:0] sb[$];
  int checks = 0, errors = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2), .id_alufun(id_alufun), .id_sign(id_sign),
    .id_wr_addr(id_wr_addr), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_wr_addr(exmem_wr_addr), .exmem_res(exmem_res),
    .memwb_regwrite(memwb_regwrite), .memwb_wr_addr(memwb_wr_addr), .memwb_data(memwb_data),
    .hold(hold), .flush(flush), .ex_a(ex_a), .ex_b(ex_b), .ex_alufun(ex_alufun), .ex_sign(ex_sign),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_wr_addr(ex_wr_addr), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  assign obs = {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_wr_addr, ex_alufun, ex_sign,
                ex_a, ex_b, ex_store_data, ex_pc};

  function automatic logic [143:0] mk(input logic v, rw, mr, mw, input logic [4:0] wr,
                                      input logic [5:0] fn, input logic sg, input logic [31:0] a, b, st, pc);
    return {v, rw, mr, mw, wr, fn, sg, a, b, st, pc};
  endfunction

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs, rt,
                        input logic urs, urt, input logic [31:0] rsd, rtd, imm, input logic [4:0] sh,
                        input logic s1, s2, input logic [5:0] fn, input logic sg,
                        input logic [4:0] wr, input logic rw, mr, mw);
    id_valid = v; id_pc = pc; id_rs_addr = rs; id_rt_addr = rt; id_use_rs = urs; id_use_rt = urt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh; id_alusrc1 = s1; id_alusrc2 = s2;
    id_alufun = fn; id_sign = sg; id_wr_addr = wr; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] ewa, input logic [31:0] eres,
                         input logic mrw, input logic [4:0] mwa, input logic [31:0] md);
    exmem_regwrite = erw; exmem_wr_addr = ewa; exmem_res = eres;
    memwb_regwrite = mrw; memwb_wr_addr = mwa; memwb_data = md;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1 sb.push_back('0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_state: got %h exp %h", obs, e); end
    checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", load_use_stall); end
    sb.push_back('0);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_held: got %h exp %h", obs, e); end
    reset = 1'b0;
  endtask

  task automatic test_capture();
    @(negedge clk);
    set_id(1, 32'h100, 1, 2, 1, 1, 5, 7, 0, 0, 0, 0, 6'h00, 0, 4, 1, 0, 0);
    sb.push_back(mk(1, 1, 0, 0, 4, 6'h00, 0, 5, 7, 7, 32'h100));
    #1 checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b exp 0", load_use_stall); end
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL capture: got %h exp %h", obs, e); end
  endtask

  task automatic test_capture_bypass();
    set_id(1, 32'h104, 6, 7, 1, 1, 32'h111, 32'h333, 0, 0, 0, 0, 6'h01, 1, 10, 1, 0, 0);
    set_fwd(0, 0, 0, 1, 6, 32'h222);
    sb.push_back(mk(1, 1, 0, 0, 10, 6'h01, 1, 32'h222, 32'h333, 32'h333, 32'h104));
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 0, 0);
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL capture_bypass: got %h exp %h", obs, e); end
  endtask

  task automatic test_forward();
    @(negedge clk);
    set_id(1, 32'h108, 3, 9, 1, 1, 1, 2, 0, 0, 0, 0, 6'h02, 0, 11, 1, 0, 0);
    sb.push_back(mk(1, 1, 0, 0, 11, 6'h02, 0, 1, 2, 2, 32'h108));
    @(negedge clk);
    idle();
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL no_fwd: got %h exp %h", obs, e); end
    set_fwd(1, 3, 32'h10, 0, 0, 0);
    sb.push_back(mk(1, 1, 0, 0, 11, 6'h02, 0, 32'h10, 2, 2, 32'h108));
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL exmem_fwd: got %h exp %h", obs, e); end
    set_fwd(1, 3, 32'h10, 1, 3, 32'h20);
    sb.push_back(mk(1, 1, 0, 0, 11, 6'h02, 0, 32'h10, 2, 2, 32'h108));
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL exmem_priority: got %h exp %h", obs, e); end
    set_fwd(1, 9, 32'h30, 1, 3, 32'h20);
    sb.push_back(mk(1, 1, 0, 0, 11, 6'h02, 0, 32'h20, 32'h30, 32'h30, 32'h108));
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL memwb_rs_exmem_rt: got %h exp %h", obs, e); end
    set_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_id(1, 32'h200, 1, 0, 1, 0, 32'h40, 0, 4, 0, 0, 1, 6'h00, 0, 8, 1, 1, 0);
    sb.push_back(mk(1, 1, 1, 0, 8, 6'h00, 0, 32'h40, 4, 0, 32'h200));
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL load_capture: got %h exp %h", obs, e); end
    set_id(1, 32'h204, 2, 8, 1, 1, 3, 32'hdead, 0, 0, 0, 0, 6'h03, 1, 9, 1, 0, 0);
    #1 checks++;
    if (load_use_stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b exp 1", load_use_stall); end
    sb.push_back('0);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL stall_bubble: got %h exp %h", obs, e); end
    checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL stall_clears: got %b exp 0", load_use_stall); end
    sb.push_back(mk(1, 1, 0, 0, 9, 6'h03, 1, 3, 32'hbeef, 32'hbeef, 32'h204));
    @(negedge clk);
    idle();
    set_fwd(0, 0, 0, 1, 8, 32'hbeef);
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL load_memwb_fwd: got %h exp %h", obs, e); end
    set_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hold_flush();
    @(negedge clk);
    set_id(1, 32'h300, 4, 5, 1, 1, 32'h11, 32'h22, 0, 0, 0, 0, 6'h04, 0, 8, 1, 1, 0);
    sb.push_back(mk(1, 1, 1, 0, 8, 6'h04, 0, 32'h11, 32'h22, 32'h22, 32'h300));
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL hold_setup: got %h exp %h", obs, e); end
    set_id(1, 32'h304, 8, 6, 1, 1, 32'h55, 32'h66, 0, 0, 0, 0, 6'h05, 0, 12, 1, 0, 1);
    hold = 1'b1; flush = 1'b1;
    #1 checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL flush_masks_stall: got %b exp 0", load_use_stall); end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(1, 1, 1, 0, 8, 6'h04, 0, 32'h11, 32'h22, 32'h22, 32'h300));
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL hold_cycle%0d: got %h exp %h", i, obs, e); end
    end
    hold = 1'b0;
    sb.push_back('0);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flush_bubble: got %h exp %h", obs, e); end
    flush = 1'b0;
    idle();
  endtask

  task automatic test_reg0();
    @(negedge clk);
    set_id(1, 32'h400, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 6'h05, 0, 0, 1, 1, 0);
    set_fwd(0, 0, 0, 1, 0, 32'h55);
    sb.push_back(mk(1, 1, 1, 0, 0, 6'h05, 0, 0, 0, 0, 32'h400));
    @(negedge clk);
    set_fwd(1, 0, 32'hffff, 1, 0, 32'h55);
    set_id(1, 32'h404, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 6'h06, 0, 1, 1, 0, 0);
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reg0_no_fwd: got %h exp %h", obs, e); end
    checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reg0_no_stall: got %b exp 0", load_use_stall); end
    idle();
    set_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_shift_async_reset();
    @(negedge clk);
    set_id(1, 32'h500, 2, 1, 0, 1, 32'h99, 1, 0, 4, 1, 0, 6'b100000, 0, 13, 1, 0, 0);
    sb.push_back(mk(1, 1, 0, 0, 13, 6'b100000, 0, 4, 1, 1, 32'h500));
    @(negedge clk);
    idle();
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL shift: got %h exp %h", obs, e); end
    reset = 1'b1;
    sb.push_back('0);
    #1 e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL async_reset: got %h exp %h", obs, e); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 32'h600, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 6'h00, 0, 7, 1, 1, 0);
    sb.push_back(mk(1, 1, 1, 0, 7, 6'h00, 0, 1, 0, 0, 32'h600));
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL stall_setup: got %h exp %h", obs, e); end
    set_id(1, 32'h604, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0, 14, 1, 0, 0);
    #1 checks++;
    if (load_use_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b exp 1", load_use_stall); end
    reset = 1'b1;
    #1 checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_drops_stall: got %b exp 0", load_use_stall); end
    sb.push_back('0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_mid_stall: got %h exp %h", obs, e); end
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    set_fwd(0, 0, 0, 0, 0, 0);
    hold = 1'b0; flush = 1'b0;
    test_reset();
    test_capture();
    test_capture_bypass();
    test_forward();
    test_load_use();
    test_hold_flush();
    test_reg0();
    test_shift_async_reset();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
